// File: rtl/int_req_ctrl_pkg.sv
// Shared constants for the interrupt request controller: vector base/offsets,
// FSM state encoding and the CPU sequencer CAR_* step codes.
package int_req_ctrl_pkg;

   localparam logic [15:0] VEC_BASE_DEF = 16'hFFE0;
   localparam logic [15:0] NMI_VEC_OFS  = 16'h001C;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_t;

   localparam logic [2:0] CAR_INT0 = 3'd0;
   localparam logic [2:0] CAR_INT1 = 3'd1;
   localparam logic [2:0] CAR_INT2 = 3'd2;
   localparam logic [2:0] CAR_INT3 = 3'd3;
   localparam logic [2:0] CAR_INT4 = 3'd4;

   // Word-aligned vector slot for a maskable source index.
   function automatic logic [15:0] vec_addr(input logic [15:0] base, input logic [15:0] idx);
      return base + (idx << 1);
   endfunction

endpackage

// File: rtl/int_req_ctrl_if.sv
// Interrupt controller <-> CPU/peripheral signal bundle.
// master drives sources and sequencer handshakes; slave is the controller.
interface int_req_ctrl_if #(parameter int NSRC = 14);

   logic [NSRC-1:0] irq_src;
   logic [NSRC-1:0] ien;
   logic            GIE;
   logic            nmi;
   logic            INTACK;
   logic            INTDONE;
   logic            INTREQ;
   logic [15:0]     vector;
   logic [NSRC-1:0] pending;

   modport master (
      output irq_src, ien, GIE, nmi, INTACK, INTDONE,
      input  INTREQ, vector, pending
   );

   modport slave (
      input  irq_src, ien, GIE, nmi, INTACK, INTDONE,
      output INTREQ, vector, pending
   );

endinterface

// File: rtl/int_req_ctrl_prio_enc.sv
// Combinational priority encoder: highest set request bit wins.
// Zero latency; o_vld low when no request is set.
module int_prio_enc #(
   parameter int N  = 14,
   parameter int IW = 4
) (
   input  logic [N-1:0]  i_req,
   output logic [IW-1:0] o_idx,
   output logic          o_vld
);

   always_comb begin
      o_idx = '0;
      o_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i_req[i]) begin
            o_idx = IW'(i);
            o_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/int_req_ctrl.sv
// Interrupt request controller: edge-detect sources, arbitrate, raise INTREQ, supply vector.
// Source edge -> pending +1 cycle -> INTREQ +2; optional NMI path under INT_REQ_CTRL_NMI_EN.
module int_req_ctrl import int_req_ctrl_pkg::*; #(
   parameter int          NSRC     = 14,
   parameter logic [15:0] VEC_BASE = VEC_BASE_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   int_req_ctrl_if.slave  bus
);

   localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

   irq_state_t      r_state;
   logic            r_intreq;
   logic [15:0]     r_vector;
   logic [NSRC-1:0] r_irq_q;
   logic [NSRC-1:0] r_pending;
   logic [IW-1:0]   r_sel;

   logic [NSRC-1:0] w_rise;
   logic [NSRC-1:0] w_elig;
   logic [NSRC-1:0] w_clr;
   logic [IW-1:0]   w_idx;
   logic            w_vld;
   logic            w_nmi_pend;
   logic            w_sel_nmi;
   logic            w_any;
   logic            w_arb;
   logic            w_ack;
   logic [15:0]     w_ack_vec;

   assign w_rise = bus.irq_src & ~r_irq_q;
   assign w_elig = r_pending & bus.ien & {NSRC{bus.GIE}};

   int_prio_enc #(.N(NSRC), .IW(IW)) u_prio_enc (
      .i_req (w_elig),
      .o_idx (w_idx),
      .o_vld (w_vld)
   );

   assign w_any = w_vld | w_nmi_pend;
   // sel follows the live winner in IDLE/REQ; frozen from INTACK until back in IDLE
   assign w_arb = w_any && ((r_state == ST_IDLE) || (r_state == ST_REQ && !bus.INTACK));
   assign w_ack = (r_state == ST_REQ) && w_any && bus.INTACK;

   always_comb begin
      w_clr = '0;
      if (w_ack && !w_sel_nmi)
         w_clr = NSRC'(1) << r_sel;
   end

`ifdef INT_REQ_CTRL_NMI_EN
   logic r_nmi_q;
   logic r_nmi_pend;
   logic r_nmi_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nmi_q    <= 1'b0;
         r_nmi_pend <= 1'b0;
         r_nmi_sel  <= 1'b0;
      end else begin
         r_nmi_q    <= bus.nmi;
         r_nmi_pend <= (r_nmi_pend & ~(w_ack & r_nmi_sel)) | (bus.nmi & ~r_nmi_q);
         if (w_arb)
            r_nmi_sel <= r_nmi_pend;
      end
   end

   assign w_nmi_pend = r_nmi_pend;
   assign w_sel_nmi  = r_nmi_sel;
   assign w_ack_vec  = r_nmi_sel ? (VEC_BASE + NMI_VEC_OFS) : vec_addr(VEC_BASE, 16'(r_sel));
`else
   assign w_nmi_pend = 1'b0;
   assign w_sel_nmi  = 1'b0;
   assign w_ack_vec  = vec_addr(VEC_BASE, 16'(r_sel));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_intreq  <= 1'b0;
         r_vector  <= 16'h0000;
         r_irq_q   <= '0;
         r_pending <= '0;
         r_sel     <= '0;
      end else begin
         r_irq_q   <= bus.irq_src;
         // a new edge on the bit being acknowledged survives the clear
         r_pending <= (r_pending & ~w_clr) | w_rise;
         if (w_arb)
            r_sel <= w_idx;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state  <= ST_REQ;
                  r_intreq <= 1'b1;
               end
            end
            ST_REQ: begin
               if (!w_any) begin
                  r_state  <= ST_IDLE;
                  r_intreq <= 1'b0;
               end else if (bus.INTACK) begin
                  r_state  <= ST_SERVICE;
                  r_intreq <= 1'b0;
                  r_vector <= w_ack_vec;
               end
            end
            ST_SERVICE: begin
               if (bus.INTDONE)
                  r_state <= ST_IDLE;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_intreq <= 1'b0;
            end
         endcase
      end
   end

   assign bus.INTREQ  = r_intreq;
   assign bus.vector  = r_vector;
   assign bus.pending = r_pending;

endmodule

// File: tb/tb_int_req_ctrl.sv
// Directed bench for int_req_ctrl: per-cycle vector table plus reset/NMI sequences.
module tb_int_req_ctrl;

   localparam logic [13:0] ALL = 14'h3FFF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int_req_ctrl_if #(.NSRC(14)) bus();

   int_req_ctrl #(.NSRC(14), .VEC_BASE(16'hFFE0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [13:0] irq;
      logic [13:0] ien;
      logic        gie;
      logic        ack;
      logic        done;
      logic        x_req;
      logic [15:0] x_vec;
      logic [13:0] x_pend;
   } vec_t;

   vec_t tbl[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic [13:0] irq, input logic [13:0] ien,
                               input logic gie, input logic ack, input logic done,
                               input logic req, input logic [15:0] vec, input logic [13:0] pend);
      tbl.push_back('{irq, ien, gie, ack, done, req, vec, pend});
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      bus.irq_src = '0;
      bus.ien     = ALL;
      bus.GIE     = 1'b1;
      bus.nmi     = 1'b0;
      bus.INTACK  = 1'b0;
      bus.INTDONE = 1'b0;
      rst_n       = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset INTREQ",  32'(bus.INTREQ),  32'h0);
      chk("reset vector",  32'(bus.vector),  32'h0);
      chk("reset pending", 32'(bus.pending), 32'h0);
      rst_n = 1'b1;

      //   irq      ien      gie ack done req  vector    pending
      add(14'h0008, ALL,     1, 0, 0, 0, 16'h0000, 14'h0008);
      add(14'h0008, ALL,     1, 0, 0, 1, 16'h0000, 14'h0008);
      add(14'h0008, ALL,     1, 1, 0, 0, 16'hFFE6, 14'h0000);
      add(14'h0008, ALL,     1, 0, 1, 0, 16'hFFE6, 14'h0000);
      add(14'h0000, ALL,     1, 0, 0, 0, 16'hFFE6, 14'h0000);
      add(14'h0204, ALL,     1, 0, 0, 0, 16'hFFE6, 14'h0204);
      add(14'h0204, ALL,     1, 0, 0, 1, 16'hFFE6, 14'h0204);
      add(14'h0204, ALL,     1, 1, 0, 0, 16'hFFF2, 14'h0004);
      add(14'h0204, ALL,     1, 0, 1, 0, 16'hFFF2, 14'h0004);
      add(14'h0204, ALL,     1, 0, 0, 1, 16'hFFF2, 14'h0004);
      add(14'h0204, ALL,     1, 1, 0, 0, 16'hFFE4, 14'h0000);
      add(14'h0000, ALL,     1, 0, 1, 0, 16'hFFE4, 14'h0000);
      add(14'h0020, ALL,     0, 0, 0, 0, 16'hFFE4, 14'h0020);
      add(14'h0020, ALL,     0, 0, 0, 0, 16'hFFE4, 14'h0020);
      add(14'h0020, ALL,     0, 1, 0, 0, 16'hFFE4, 14'h0020);
      add(14'h0020, ALL,     1, 0, 0, 1, 16'hFFE4, 14'h0020);
      add(14'h0020, ALL,     1, 0, 0, 1, 16'hFFE4, 14'h0020);
      add(14'h0020, ALL,     0, 0, 0, 0, 16'hFFE4, 14'h0020);
      add(14'h0020, ALL,     0, 0, 1, 0, 16'hFFE4, 14'h0020);
      add(14'h0020, ALL,     1, 0, 0, 1, 16'hFFE4, 14'h0020);
      add(14'h0820, ALL,     1, 0, 0, 1, 16'hFFE4, 14'h0820);
      add(14'h0820, ALL,     1, 0, 0, 1, 16'hFFE4, 14'h0820);
      add(14'h0820, ALL,     1, 1, 0, 0, 16'hFFF6, 14'h0020);
      add(14'h0822, ALL,     1, 0, 0, 0, 16'hFFF6, 14'h0022);
      add(14'h0822, ALL,     1, 1, 0, 0, 16'hFFF6, 14'h0022);
      add(14'h0822, ALL,     1, 0, 1, 0, 16'hFFF6, 14'h0022);
      add(14'h0822, ALL,     1, 0, 0, 1, 16'hFFF6, 14'h0022);
      add(14'h0822, ALL,     1, 1, 0, 0, 16'hFFEA, 14'h0002);
      add(14'h0822, ALL,     1, 0, 1, 0, 16'hFFEA, 14'h0002);
      add(14'h0822, ALL,     1, 0, 0, 1, 16'hFFEA, 14'h0002);
      add(14'h0822, ALL,     1, 1, 0, 0, 16'hFFE2, 14'h0000);
      add(14'h0000, ALL,     1, 0, 1, 0, 16'hFFE2, 14'h0000);
      add(14'h0008, ALL,     1, 0, 0, 0, 16'hFFE2, 14'h0008);
      add(14'h0000, ALL,     1, 0, 0, 1, 16'hFFE2, 14'h0008);
      add(14'h0008, ALL,     1, 1, 0, 0, 16'hFFE6, 14'h0008);
      add(14'h0008, ALL,     1, 0, 1, 0, 16'hFFE6, 14'h0008);
      add(14'h0000, ALL,     1, 0, 0, 1, 16'hFFE6, 14'h0008);
      add(14'h0000, ALL,     1, 1, 0, 0, 16'hFFE6, 14'h0000);
      add(14'h0000, ALL,     1, 0, 1, 0, 16'hFFE6, 14'h0000);
      add(14'h0010, ALL,     1, 0, 0, 0, 16'hFFE6, 14'h0010);
      add(14'h0010, ALL,     1, 0, 0, 1, 16'hFFE6, 14'h0010);
      add(14'h0010, 14'h3FEF,1, 0, 0, 0, 16'hFFE6, 14'h0010);
      add(14'h0010, 14'h3FEF,1, 1, 0, 0, 16'hFFE6, 14'h0010);
      add(14'h0010, ALL,     1, 0, 0, 1, 16'hFFE6, 14'h0010);
      add(14'h0010, ALL,     1, 1, 0, 0, 16'hFFE8, 14'h0000);
      add(14'h0000, ALL,     1, 0, 1, 0, 16'hFFE8, 14'h0000);
      add(14'h2000, ALL,     1, 0, 0, 0, 16'hFFE8, 14'h2000);
      add(14'h2000, ALL,     1, 0, 0, 1, 16'hFFE8, 14'h2000);
      add(14'h2000, ALL,     1, 1, 0, 0, 16'hFFFA, 14'h0000);
      add(14'h0000, ALL,     1, 0, 1, 0, 16'hFFFA, 14'h0000);

      foreach (tbl[i]) begin
         bus.irq_src = tbl[i].irq;
         bus.ien     = tbl[i].ien;
         bus.GIE     = tbl[i].gie;
         bus.INTACK  = tbl[i].ack;
         bus.INTDONE = tbl[i].done;
         tick();
         chk($sformatf("row%0d INTREQ", i),  32'(bus.INTREQ),  32'(tbl[i].x_req));
         chk($sformatf("row%0d vector", i),  32'(bus.vector),  32'(tbl[i].x_vec));
         chk($sformatf("row%0d pending", i), 32'(bus.pending), 32'(tbl[i].x_pend));
      end
      bus.INTACK  = 1'b0;
      bus.INTDONE = 1'b0;
      bus.GIE     = 1'b1;
      bus.ien     = ALL;

`ifdef INT_REQ_CTRL_NMI_EN
      // NMI is taken with GIE low and vectors to the fixed NMI slot
      bus.GIE = 1'b0;
      bus.nmi = 1'b1;
      tick();
      tick();
      chk("nmi INTREQ", 32'(bus.INTREQ), 32'h1);
      bus.INTACK = 1'b1;
      tick();
      chk("nmi vector", 32'(bus.vector), 32'hFFFC);
      chk("nmi ack INTREQ", 32'(bus.INTREQ), 32'h0);
      bus.INTACK  = 1'b0;
      bus.INTDONE = 1'b1;
      tick();
      bus.INTDONE = 1'b0;
      tick();
      chk("nmi cleared INTREQ", 32'(bus.INTREQ), 32'h0);
      bus.nmi = 1'b0;
      bus.GIE = 1'b1;
      tick();
`endif

      // Reset in REQ drops INTREQ and pending without waiting for a clock edge
      bus.irq_src = 14'h0001;
      tick();
      tick();
      chk("pre-reset INTREQ", 32'(bus.INTREQ), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset INTREQ",  32'(bus.INTREQ),  32'h0);
      chk("async reset pending", 32'(bus.pending), 32'h0);
      chk("async reset vector",  32'(bus.vector),  32'h0);
      bus.irq_src = 14'h0040;
      tick();
      bus.irq_src = 14'h0000;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("lost edge pending", 32'(bus.pending), 32'h0);
      chk("lost edge INTREQ",  32'(bus.INTREQ),  32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
